multicycle_ctrl_unit: RTL and testbench
=======================================

// Module: multicycle_ctrl_unit
// PURPOSE
//  Parametrised multicycle RV32I control FSM; drives the datapath (PC, regfile, ALU, WB mux) and the APB master request.
//  Adds over the fixed-latency controller: programmable fetch wait states, a bus-ready timeout and trap reporting.
//  Trap causes are illegal opcode and bus timeout; trap reporting is gated by EN_TRAP.
//  Sits between the instruction register/datapath and the APB master; one instruction retires per FETCH..FETCH loop.
// PARAMETERS
//  FETCH_WAIT   1   cycles spent in WAIT after FETCH before DECODE (0..15; 0 = FETCH->DECODE directly)
//  BUS_TIMEOUT  16  max cycles in S_MEM/L_MEM without ready before a timeout trap (1..255)
//  EN_TRAP      1   1: illegal opcode / timeout go to TRAP; 0: illegal->FETCH (NOP), MEM waits on ready forever
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset (0 = reset)
//  instrCode      in   32  current instruction (IR output)
//  ready          in   1   APB completion from the bus master
//  PCEn           out  1   PC register load enable
//  regFileWe      out  1   register-file write enable
//  aluControl     out  4   ALU op, {func7[5],func3} unless overridden
//  aluSrcMuxSel   out  1   0: rs2, 1: immediate
//  dataWe         out  1   bus write (store) qualifier
//  RFWDSrcMuxSel  out  3   WB select: 000 ALU, 001 load data, 010 LUI imm, 011 AUIPC, 100 PC+4
//  branch         out  1   branch-compare PC select
//  jal            out  1   jump PC select
//  jalr           out  1   rs1-relative jump select
//  transfer       out  1   APB request, held high for the whole MEM phase
//  trap           out  1   one-cycle trap pulse; datapath loads the trap vector into the PC
//  trapCause      out  2   00 none, 01 illegal opcode, 10 bus timeout; valid while trap=1
// BEHAVIOUR
//  States: FETCH, WAIT, DECODE, R/I/B/LU/AU/J/JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP.
//  Outputs are Moore decodes of state; aluControl alone also depends on instrCode.
//  Reset: state=FETCH, wait/timeout counters=0.
//   Outputs while in reset: PCEn=1, all other 1-bit outputs 0, RFWDSrcMuxSel=000, trapCause=00, aluControl={instrCode[30],instrCode[14:12]}.
//  FETCH: PCEn=1 for exactly 1 cycle; next is WAIT, or DECODE if FETCH_WAIT=0.
//  WAIT: wait counter loads FETCH_WAIT-1 on FETCH exit and decrements; exit to DECODE when it reaches 0.
//   Fetch-to-DECODE latency is 1+FETCH_WAIT cycles.
//  DECODE: branch on opcode[6:0]. Encodings:
//   R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
//   Any other opcode -> TRAP(cause 01) if EN_TRAP, else FETCH.
//  Single-cycle EXE states return to FETCH and set:
//   R_EXE   regFileWe.
//   I_EXE   regFileWe, aluSrc; aluControl={1'b0,func3}, except {1,101} (SRAI) is passed through.
//   B_EXE   branch.
//   LU_EXE  regFileWe, WB=010.
//   AU_EXE  regFileWe, WB=011.
//   J_EXE   regFileWe, WB=100, jal.
//   JL_EXE  regFileWe, WB=100, jal, jalr; aluControl=ADD(0000).
//  Store path:
//   S_EXE (aluSrc, ADD) -> S_MEM (aluSrc, dataWe, transfer).
//   S_MEM exits to FETCH on the cycle ready=1 is sampled.
//  Load path:
//   L_EXE (aluSrc, WB=001, ADD) -> L_MEM (aluSrc, WB=001, transfer) -> L_WB (regFileWe, aluSrc, WB=001) -> FETCH.
//   L_MEM exits to L_WB on ready=1.
//  Timeout counter (8b):
//   Clears on MEM entry; increments each MEM cycle with ready=0.
//   If EN_TRAP and count==BUS_TIMEOUT-1 with ready=0 -> TRAP(cause 10); transfer drops.
//   ready=1 on that same cycle wins: normal exit, no trap.
//   The counter saturates and never wraps.
//  TRAP: trap=1 and trapCause valid for exactly 1 cycle; PCEn=0, regFileWe=0, dataWe=0; next FETCH.
//   No regfile write is ever issued for a trapped instruction.
//  ready outside MEM states is ignored; ready already high on MEM entry completes in 1 cycle.
//  Reset asserted mid-MEM: transfer drops asynchronously, no write-back occurs.
// STRUCTURE
//  ctrl_pkg: opcode localparams, ALU op codes (ADD etc.), state_e enum, WB-select enum, trap-cause enum.
//  Sub-module bus_wait_timer: wait/timeout counter with load, enable, clear and expiry flag.
//   Instanced once and shared by WAIT and MEM states.
// TESTING
//  1. Reset low 3 cycles, release with R ADD (0x002081B3), FETCH_WAIT=1.
//     -> PCEn pulse, WAIT, DECODE, R_EXE with regFileWe=1, aluControl=0000; PCEn again 4 cycles after first.
//  2. LW (0x0000A103), ready=0 for 3 cycles then 1.
//     -> transfer high 4 cycles; L_WB regFileWe=1, WB=001; no trap.
//  3. SW (0x0020A023), ready held 0, BUS_TIMEOUT=4.
//     -> transfer 4 cycles, then trap=1, trapCause=10 for one cycle; dataWe=0 in TRAP; FETCH next.
//  4. Opcode 0x7F with EN_TRAP=1 -> trap cause 01 after DECODE; same opcode with EN_TRAP=0 -> FETCH, no outputs active.
//  5. SRAI (0x4030D093) -> aluControl=1101; SRLI (0x0030D093) -> 0101; JALR -> jal=jalr=1, WB=100, aluControl=0000.
//  6. FETCH_WAIT=0 and FETCH_WAIT=3: DECODE reached 1 and 4 cycles after FETCH; reset pulsed mid-L_MEM -> FETCH, transfer=0 at once.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU ops, FSM states and select encodings shared by the multicycle controller
package ctrl_pkg;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  typedef enum logic [3:0] {
    S_FETCH, S_WAIT, S_DECODE, S_R_EXE, S_I_EXE, S_B_EXE, S_LU_EXE, S_AU_EXE,
    S_J_EXE, S_JL_EXE, S_S_EXE, S_S_MEM, S_L_EXE, S_L_MEM, S_L_WB, S_TRAP
  } state_e;
  typedef enum logic [2:0] {
    WB_ALU = 3'b000, WB_LOAD = 3'b001, WB_LUI = 3'b010, WB_AUIPC = 3'b011, WB_PC4 = 3'b100
  } wb_e;
  typedef enum logic [1:0] {TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_TIMEOUT = 2'b10} trap_cause_e;
  // Unknown opcodes map to S_TRAP; the caller decides whether traps are enabled
  function automatic state_e decode_op(input logic [6:0] op);
    case (op)
      OP_R:    return S_R_EXE;
      OP_I:    return S_I_EXE;
      OP_L:    return S_L_EXE;
      OP_S:    return S_S_EXE;
      OP_B:    return S_B_EXE;
      OP_LU:   return S_LU_EXE;
      OP_AU:   return S_AU_EXE;
      OP_J:    return S_J_EXE;
      OP_JL:   return S_JL_EXE;
      default: return S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: saturating up/down counter with clear, load and a compare-against-limit flag
module bus_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [W-1:0] lim_i,
  output logic         hit_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr_i  ? '0
          : load_i ? val_i
          : !en_i  ? cnt_q
          : up_i   ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1)
          :          ((cnt_q == '0) ? cnt_q : cnt_q - 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign hit_o = cnt_q == lim_i;
endmodule

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: RV32I multicycle control FSM with fetch wait states, bus timeout and trap reporting
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned FETCH_WAIT  = 1,
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter bit          EN_TRAP     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        ready,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic        dataWe,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        transfer,
  output logic        trap,
  output logic [1:0]  trapCause
);
  localparam logic [7:0] WAIT_LD = (FETCH_WAIT == 0) ? 8'd0 : 8'(FETCH_WAIT - 1);
  localparam logic [7:0] TO_LIM  = 8'(BUS_TIMEOUT - 1);
  state_e      state_q, state_d, dec_st;
  trap_cause_e cause_q, cause_d;
  logic        in_mem, hit;
  logic        unused;
  assign unused = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};
  assign in_mem = state_q inside {S_S_MEM, S_L_MEM};
  assign dec_st = decode_op(instrCode[6:0]);
  // One counter serves both phases: counts down through WAIT, up through MEM
  bus_wait_timer #(.W(8)) u_tmr (
    .clk,
    .rst_n  (reset),
    .clr_i  (state_q inside {S_S_EXE, S_L_EXE}),
    .load_i (state_q == S_FETCH),
    .val_i  (WAIT_LD),
    .en_i   (state_q == S_WAIT || (in_mem && !ready)),
    .up_i   (in_mem),
    .lim_i  (in_mem ? TO_LIM : 8'd0),
    .hit_o  (hit)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_FETCH;
      cause_q <= TC_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH:  state_d = (FETCH_WAIT == 0) ? S_DECODE : S_WAIT;
      S_WAIT:   state_d = hit ? S_DECODE : S_WAIT;
      S_DECODE: begin
        state_d = (dec_st == S_TRAP && !EN_TRAP) ? S_FETCH : dec_st;
        cause_d = TC_ILLEGAL;
      end
      S_S_EXE:  state_d = S_S_MEM;
      S_L_EXE:  state_d = S_L_MEM;
      S_S_MEM, S_L_MEM: begin
        state_d = ready ? ((state_q == S_S_MEM) ? S_FETCH : S_L_WB)
                : (EN_TRAP && hit) ? S_TRAP : state_q;
        cause_d = TC_TIMEOUT;
      end
      default:  state_d = S_FETCH;
    endcase
  end
  always_comb begin
    PCEn          = state_q == S_FETCH;
    regFileWe     = state_q inside {S_R_EXE, S_I_EXE, S_LU_EXE, S_AU_EXE, S_J_EXE, S_JL_EXE, S_L_WB};
    aluSrcMuxSel  = state_q inside {S_I_EXE, S_S_EXE, S_S_MEM, S_L_EXE, S_L_MEM, S_L_WB};
    dataWe        = state_q == S_S_MEM;
    branch        = state_q == S_B_EXE;
    jal           = state_q inside {S_J_EXE, S_JL_EXE};
    jalr          = state_q == S_JL_EXE;
    transfer      = in_mem;
    trap          = state_q == S_TRAP;
    trapCause     = (state_q == S_TRAP) ? cause_q : TC_NONE;
    RFWDSrcMuxSel = (state_q == S_LU_EXE) ? WB_LUI
                  : (state_q == S_AU_EXE) ? WB_AUIPC
                  : (state_q inside {S_J_EXE, S_JL_EXE}) ? WB_PC4
                  : (state_q inside {S_L_EXE, S_L_MEM, S_L_WB}) ? WB_LOAD
                  : WB_ALU;
    aluControl    = (state_q inside {S_JL_EXE, S_S_EXE, S_L_EXE}) ? ALU_ADD
                  : {instrCode[30] & (state_q != S_I_EXE || instrCode[14:12] == 3'b101), instrCode[14:12]};
  end
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit: randomized scoreboard bench over three parameter sets of the controller
module tb_multicycle_ctrl_unit;
  typedef struct packed {
    logic       pc, we;
    logic [3:0] alu;
    logic       src, dwe;
    logic [2:0] wb;
    logic       br, jal, jalr, tr, trap;
    logic [1:0] cause;
  } out_t;
  typedef enum int {P_FETCH, P_WAIT, P_DEC, P_R, P_I, P_B, P_LU, P_AU, P_J, P_JL,
                    P_SE, P_SM, P_LE, P_LM, P_LW, P_TI, P_TO} ph_e;
  localparam int FWS [3] = '{1, 0, 3};
  localparam int BTS [3] = '{4, 3, 6};
  localparam int ENS [3] = '{1, 0, 1};
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr [3];
  logic        rdy [3];
  out_t        got [3];
  out_t        exp_q [$];
  int          ph_q [$];
  int          tr_ph [$];
  bit          tr_rd [$];
  int          act, checks, errors;
  bit          chk;
  out_t        e;
  int          p;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gd
    logic       pc, we, src, dwe, br, jl, jr, tr, tp;
    logic [3:0] alu;
    logic [2:0] wb;
    logic [1:0] cause;
    multicycle_ctrl_unit #(
      .FETCH_WAIT(FWS[g]), .BUS_TIMEOUT(BTS[g]), .EN_TRAP(ENS[g] != 0)
    ) u_dut (
      .clk(clk), .reset(reset), .instrCode(instr[g]), .ready(rdy[g]),
      .PCEn(pc), .regFileWe(we), .aluControl(alu), .aluSrcMuxSel(src), .dataWe(dwe),
      .RFWDSrcMuxSel(wb), .branch(br), .jal(jl), .jalr(jr), .transfer(tr),
      .trap(tp), .trapCause(cause)
    );
    assign got[g] = {pc, we, alu, src, dwe, wb, br, jl, jr, tr, tp, cause};
  end
  // Expected outputs of one cycle, from the phase the instruction is in
  function automatic out_t model(input int ph, input logic [31:0] ins);
    out_t o = '0;
    o.alu = {ins[30], ins[14:12]};
    case (ph)
      P_FETCH: o.pc = 1'b1;
      P_R:     o.we = 1'b1;
      P_I:     begin o.we = 1'b1; o.src = 1'b1; o.alu[3] = ins[30] && ins[14:12] == 3'd5; end
      P_B:     o.br = 1'b1;
      P_LU:    begin o.we = 1'b1; o.wb = 3'd2; end
      P_AU:    begin o.we = 1'b1; o.wb = 3'd3; end
      P_J:     begin o.we = 1'b1; o.wb = 3'd4; o.jal = 1'b1; end
      P_JL:    begin o.we = 1'b1; o.wb = 3'd4; o.jal = 1'b1; o.jalr = 1'b1; o.alu = 4'd0; end
      P_SE:    begin o.src = 1'b1; o.alu = 4'd0; end
      P_SM:    begin o.src = 1'b1; o.dwe = 1'b1; o.tr = 1'b1; end
      P_LE:    begin o.src = 1'b1; o.wb = 3'd1; o.alu = 4'd0; end
      P_LM:    begin o.src = 1'b1; o.wb = 3'd1; o.tr = 1'b1; end
      P_LW:    begin o.we = 1'b1; o.src = 1'b1; o.wb = 3'd1; end
      P_TI:    begin o.trap = 1'b1; o.cause = 2'd1; end
      P_TO:    begin o.trap = 1'b1; o.cause = 2'd2; end
      default: ;
    endcase
    return o;
  endfunction
  function automatic void add(input int ph, input bit r);
    tr_ph.push_back(ph);
    tr_rd.push_back(r);
  endfunction
  function automatic bit legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    logic [31:0] r = $urandom;
    int          c = $urandom_range(0, 10);
    if (c < 9) r[6:0] = ops[c];
    else while (legal(r[6:0])) r[6:0] = 7'($urandom);
    return r;
  endfunction
  always @(negedge clk) if (chk) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL dut%0d scoreboard empty: got %h, required an expectation", act, got[act]);
    end else begin
      e = exp_q.pop_front();
      p = ph_q.pop_front();
      if (got[act] !== e) begin
        errors++;
        $display("FAIL dut%0d phase %0d: got %h required %h", act, p, got[act], e);
      end
    end
  end
  task automatic cycle(input logic [31:0] ins, input bit r, input logic rst, input int ph);
    @(posedge clk);
    #1;
    reset = rst;
    instr[act] = ins;
    rdy[act] = r;
    exp_q.push_back(model(ph, ins));
    ph_q.push_back(ph);
  endtask
  // k = ready-low cycles before ready rises in MEM; rst_at = trace index where reset hits
  task automatic run_instr(input logic [31:0] ins, input int k, input int rst_at);
    int fw = FWS[act];
    int bt = BTS[act];
    bit en = ENS[act] != 0;
    bit st = ins[6:0] == 7'b0100011;
    tr_ph.delete();
    tr_rd.delete();
    add(P_FETCH, 1'($urandom));
    repeat (fw) add(P_WAIT, 1'($urandom));
    add(P_DEC, 1'($urandom));
    case (ins[6:0])
      7'b0110011: add(P_R, 1'($urandom));
      7'b0010011: add(P_I, 1'($urandom));
      7'b1100011: add(P_B, 1'($urandom));
      7'b0110111: add(P_LU, 1'($urandom));
      7'b0010111: add(P_AU, 1'($urandom));
      7'b1101111: add(P_J, 1'($urandom));
      7'b1100111: add(P_JL, 1'($urandom));
      7'b0100011, 7'b0000011: begin
        add(st ? P_SE : P_LE, 1'($urandom));
        if (en && k >= bt) begin
          repeat (bt) add(st ? P_SM : P_LM, 1'b0);
          add(P_TO, 1'($urandom));
        end else begin
          for (int j = 0; j <= k; j++) add(st ? P_SM : P_LM, j == k);
          if (!st) add(P_LW, 1'($urandom));
        end
      end
      default: if (en) add(P_TI, 1'($urandom));
    endcase
    for (int i = 0; i < tr_ph.size(); i++) begin
      if (i == rst_at) begin
        repeat (2) cycle(ins, 1'($urandom), 1'b0, P_FETCH);
        return;
      end
      cycle(ins, tr_rd[i], 1'b1, tr_ph[i]);
    end
  endtask
  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr[i] = '0;
      rdy[i] = 1'b0;
    end
    act = 0;
    checks = 0;
    errors = 0;
    chk = 1'b1;
    for (int d = 0; d < 3; d++) begin
      if (d != 0) @(negedge clk);
      #1 act = d;
      repeat (3) cycle(instr[d], 1'($urandom), 1'b0, P_FETCH);
      case (d)
        0: begin
          run_instr(32'h002081B3, 0, -1);
          run_instr(32'h0000A103, 3, -1);
          run_instr(32'h0020A023, 99, -1);
          run_instr(32'h0020A023, 3, -1);
          run_instr(32'h0000007F, 0, -1);
          run_instr(32'h4030D093, 0, -1);
          run_instr(32'h0030D093, 0, -1);
          run_instr(32'h000080E7, 0, -1);
          run_instr(32'h0000A103, 5, 5);
        end
        1: begin
          run_instr(32'h0000007F, 0, -1);
          run_instr(32'h0020A023, 10, -1);
          run_instr(32'h0000A103, 0, -1);
        end
        default: begin
          run_instr(32'h0020A023, 5, -1);
          run_instr(32'h0020A023, 6, -1);
          run_instr(32'h0000A103, 20, -1);
        end
      endcase
      repeat (40) run_instr(rand_instr(), $urandom_range(0, BTS[d] + 2), -1);
    end
    @(negedge clk);
    #1 chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
